// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin front end for one shared, non-stallable
// 32x32 signed multiplier. Issues at most one operand pair per cycle, tags
// it with the requester ID, delays the tag to line up with the product and
// steers the 64-bit result back to its owner. Per-requester credit counters
// bound the number of operations each requester may have in flight.
module mul_share_sched #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 9,
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_p,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_p,
  output logic                 busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   ptr_next;
  logic [CW-1:0]    cnt_reg [NREQ];
  logic [NREQ-1:0]  elig;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [IDW:0]     scan_idx;
  logic [IDW:0]     ptr_inc;
  logic [NREQ-1:0]  grant_vec;
  logic [31:0]      a_arr [NREQ];
  logic [31:0]      b_arr [NREQ];

  logic [MUL_LAT-1:0] vld_pipe_reg;
  logic [IDW-1:0]     id_pipe_reg [MUL_LAT];
  logic               last_vld;
  logic [IDW-1:0]     last_id;

  // Unpack operands, qualify eligibility and decode the one-hot grant/response
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign a_arr[gi]     = req_a[32*gi +: 32];
    assign b_arr[gi]     = req_b[32*gi +: 32];
    // rst gates the grant so nothing is handshaken while reset is held
    assign elig[gi]      = req_valid[gi] && (cnt_reg[gi] < CW'(MAX_OUT)) && !flush && !rst;
    assign grant_vec[gi] = grant_any && (grant_id == IDW'(gi));
    assign rsp_valid[gi] = last_vld && !flush && (last_id == IDW'(gi));
  end

  assign req_ready = grant_vec;
  assign last_vld  = vld_pipe_reg[MUL_LAT-1];
  assign last_id   = id_pipe_reg[MUL_LAT-1];
  assign rsp_p     = mul_p;
  assign busy      = |vld_pipe_reg;
  assign mul_a     = grant_any ? a_arr[grant_id] : 32'd0;
  assign mul_b     = grant_any ? b_arr[grant_id] : 32'd0;

  // Round-robin search starting at the pointer, wrapping modulo NREQ
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (!grant_any && elig[scan_idx[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx[IDW-1:0];
      end
    end
  end

  // Next pointer: one past the winner, or hold when nothing was granted
  always_comb begin
    ptr_inc  = {1'b0, grant_id} + (IDW+1)'(1);
    ptr_next = ptr_reg;
    if (grant_any) begin
      if (ptr_inc == (IDW+1)'(NREQ)) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr_inc[IDW-1:0];
      end
    end
  end

  // Pointer register; flush deliberately leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Tag delay line matched to the multiplier latency; flush kills every stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_reg <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        id_pipe_reg[s] <= '0;
      end
    end else begin
      // grant_any is already low during flush, so stage 0 clears too
      vld_pipe_reg[0] <= grant_any;
      id_pipe_reg[0]  <= grant_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_pipe_reg[s] <= flush ? 1'b0 : vld_pipe_reg[s-1];
        id_pipe_reg[s]  <= id_pipe_reg[s-1];
      end
    end
  end

  // Outstanding-operation credit counters: +1 on grant, -1 on response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_reg[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_vec[i] && !rsp_valid[i]) begin
          cnt_reg[i] <= cnt_reg[i] + CW'(1);
        end else if (!grant_vec[i] && rsp_valid[i]) begin
          cnt_reg[i] <= cnt_reg[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with a behavioural 9-stage signed
// multiplier standing in for the shared Booth/Wallace pipeline.
module tb_mul_share_sched;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 9;
  localparam int MAX_OUT = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic [63:0]         mul_p;
  logic [NREQ-1:0]     rsp_valid;
  logic [63:0]         rsp_p;
  logic                busy;

  int errors = 0;
  int checks = 0;

  logic signed [63:0] mpipe [MUL_LAT];

  mul_share_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared multiplier stand-in: free-running, never stalls, never resets
  always @(posedge clk) begin
    mpipe[0] <= $signed(mul_a) * $signed(mul_b);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[MUL_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = v;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) next_cyc();
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = 1'b0;
    #1 rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    next_cyc();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_a = '0; req_b = '0; req_valid = 4'hF;
    for (int k = 0; k < MUL_LAT; k++) mpipe[k] = '0;

    // Reset state: ready is suppressed even with every request valid
    next_cyc();
    #2;
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    req_valid = '0;
    rst = 1'b0;
    next_cyc();
    chk("idle_busy", 64'(busy), 64'h0);

    // Single op: 7 * -3 from requester 0
    set_req(0, 1'b1, 32'd7, 32'hFFFFFFFD);
    #2;
    chk("single_ready", 64'(req_ready), 64'h1);
    chk("single_mul_a", 64'(mul_a), 64'h7);
    chk("single_mul_b", 64'(mul_b), 64'hFFFFFFFD);
    next_cyc();
    req_valid = '0;
    for (int c = 1; c <= 10; c++) begin
      #2;
      chk($sformatf("single_busy_c%0d", c), 64'(busy), (c <= 9) ? 64'h1 : 64'h0);
      chk($sformatf("single_rsp_valid_c%0d", c), 64'(rsp_valid), (c == 9) ? 64'h1 : 64'h0);
      if (c == 9) chk("single_rsp_p", rsp_p, 64'hFFFFFFFFFFFFFFEB);
      next_cyc();
    end
    do_reset();

    // Fairness: all four valid, a = i+1, b = 10
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i + 1), 32'd10);
    for (int c = 0; c <= 16; c++) begin
      #2;
      chk($sformatf("fair_ready_c%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
      if (c >= 9) begin
        chk($sformatf("fair_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(1 << ((c - 9) % 4)));
        chk($sformatf("fair_rsp_p_c%0d", c), rsp_p, 64'(10 * (((c - 9) % 4) + 1)));
      end else begin
        chk($sformatf("fair_rsp_valid_c%0d", c), 64'(rsp_valid), 64'h0);
      end
      next_cyc();
    end
    idle(14);
    do_reset();

    // Credit cap: requester 0 alone, 2 * 3
    set_req(0, 1'b1, 32'd2, 32'd3);
    for (int c = 0; c <= 14; c++) begin
      #2;
      chk($sformatf("cap_ready_c%0d", c), 64'(req_ready),
          ((c <= 3) || (c >= 10 && c <= 13)) ? 64'h1 : 64'h0);
      chk($sformatf("cap_rsp_valid_c%0d", c), 64'(rsp_valid),
          (c >= 9 && c <= 12) ? 64'h1 : 64'h0);
      if (c >= 9 && c <= 12) chk($sformatf("cap_rsp_p_c%0d", c), rsp_p, 64'd6);
      next_cyc();
    end
    idle(14);
    do_reset();

    // Extreme operands
    set_req(0, 1'b1, 32'h80000000, 32'h80000000);
    next_cyc();
    set_req(0, 1'b1, 32'h7FFFFFFF, 32'h80000000);
    #2;
    chk("ext_ready_c1", 64'(req_ready), 64'h1);
    next_cyc();
    req_valid = '0;
    for (int c = 2; c <= 10; c++) begin
      #2;
      if (c == 9) begin
        chk("ext_rsp_valid_c9", 64'(rsp_valid), 64'h1);
        chk("ext_rsp_p_min_min", rsp_p, 64'h4000000000000000);
      end
      if (c == 10) begin
        chk("ext_rsp_valid_c10", 64'(rsp_valid), 64'h1);
        chk("ext_rsp_p_max_min", rsp_p, 64'hC000000080000000);
      end
      next_cyc();
    end
    idle(2);
    do_reset();

    // Flush: requesters 1 and 2 issue, then flush in cycle 3
    set_req(1, 1'b1, 32'd5, 32'd5);
    #2;
    chk("flush_ready_c0", 64'(req_ready), 64'h2);
    next_cyc();
    req_valid = '0;
    set_req(2, 1'b1, 32'd6, 32'd6);
    #2;
    chk("flush_ready_c1", 64'(req_ready), 64'h4);
    next_cyc();
    req_valid = '0;
    next_cyc();
    flush = 1'b1;
    set_req(3, 1'b1, 32'd3, 32'hFFFFFFFC);
    #2;
    chk("flush_ready_during", 64'(req_ready), 64'h0);
    next_cyc();
    flush = 1'b0;
    #2;
    chk("flush_busy_c4", 64'(busy), 64'h0);
    chk("flush_ready_c4", 64'(req_ready), 64'h8);
    next_cyc();
    req_valid = '0;
    for (int c = 5; c <= 14; c++) begin
      #2;
      chk($sformatf("flush_rsp_valid_c%0d", c), 64'(rsp_valid), (c == 13) ? 64'h8 : 64'h0);
      if (c == 13) chk("flush_rsp_p", rsp_p, 64'hFFFFFFFFFFFFFFF4);
      next_cyc();
    end
    do_reset();

    // Async reset mid-flight: three ops, then rst between edges in cycle 5
    for (int c = 0; c <= 2; c++) begin
      set_req(0, 1'b1, 32'(c + 2), 32'd9);
      next_cyc();
    end
    req_valid = '0;
    next_cyc();
    next_cyc();
    set_req(1, 1'b1, 32'd1, 32'd1);
    #2;
    chk("arst_busy_before", 64'(busy), 64'h1);
    chk("arst_ready_before", 64'(req_ready), 64'h2);
    rst = 1'b1;
    #1;
    chk("arst_busy_now", 64'(busy), 64'h0);
    chk("arst_ready_now", 64'(req_ready), 64'h0);
    chk("arst_rsp_valid_now", 64'(rsp_valid), 64'h0);
    next_cyc();
    #2 rst = 1'b0;
    req_valid = '0;
    next_cyc();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'd4, 32'd4);
    #2;
    chk("arst_ptr_zero", 64'(req_ready), 64'h1);
    next_cyc();
    req_valid = '0;
    for (int c = 8; c <= 17; c++) begin
      #2;
      chk($sformatf("arst_rsp_valid_c%0d", c), 64'(rsp_valid), (c == 16) ? 64'h1 : 64'h0);
      if (c == 16) chk("arst_rsp_p", rsp_p, 64'd16);
      next_cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
